console_port: RTL
=================

# console_port

Memory-mapped console peripheral for the CPU6 system bus: a parametrised, synthesizable successor to the testbench-only UART and simulation-stop hack. CPU byte writes to the data register are buffered in a FIFO and serialised as 8N1 frames on `tx`. A status register is readable over the bus, and a halt register raises a sticky `halt` flag that benches use to end simulation. It sits beside `Memory` on the CPU6 address/data bus; the top level uses `selected` to mux `read_data` into the CPU's read data path.

## Interface
- `BASE_ADDR`, 16'h5a00: address of the data register; the status register is at BASE_ADDR+1.
- `HALT_ADDR`, 16'h5b00: address of the halt register.
- `HALT_CODE`, 8'h5a: value that sets `halt` when written to HALT_ADDR.
- `DEPTH`, 16: number of FIFO entries; a power of two, ≥2.
- `DIVISOR`, 16: clocks per serial bit; ≥2.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  16  CPU address bus.
- `write_en`  in  1  CPU write strobe, sampled at the clock edge.
- `write_data`  in  8  CPU write data.
- `read_data`  out  8  register read data, combinational from `address`; 0 when not selected.
- `selected`  out  1  high when `address` is BASE_ADDR, BASE_ADDR+1 or HALT_ADDR.
- `tx`  out  1  serial output; idle level is 1.
- `halt`  out  1  sticky halt flag.
- `fifo_level`  out  $clog2(DEPTH)+1  number of occupied FIFO entries.

## Operation
- Write to BASE_ADDR:
  - If the FIFO is not full, or a pop occurs in the same cycle, push `write_data`.
  - Otherwise drop the byte and set the sticky `overflow` flag.
- Status read at BASE_ADDR+1:
  - bit0 = full, bit1 = empty, bit2 = busy (FSM not in IDLE), bit3 = overflow; bits 7:4 = 0.
  - Reads have no side effects.
- Any write to BASE_ADDR+1 clears `overflow`.
  - If an overflow occurs in the same cycle as this clear, the set wins.
- Write of HALT_CODE to HALT_ADDR sets `halt`. Any other value is ignored.
  - `halt` clears only on reset.
  - Reading HALT_ADDR returns {7'b0, halt}.
- Reading BASE_ADDR returns 0; the data register is write-only.
- Transmit FSM:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a shift register and go to START.
  - START: `tx`=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0], LSB first, each bit DIVISOR cycles. After bit 7 go to STOP.
  - STOP: `tx`=1 for DIVISOR cycles.
    - If the FIFO is non-empty at the end, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Bit counter is 3 bits; divisor counter is $clog2(DIVISOR) bits, counting down from DIVISOR-1 to 0.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. The count is tracked separately, so full and empty are never ambiguous.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, FIFO emptied, `tx`=1, `halt`=0, `overflow`=0, `fifo_level`=0.
  - The in-flight frame is abandoned.

## Timing
- A write is accepted at rising edge N; `fifo_level` reflects it after edge N.
- With the FSM in IDLE, the pop occurs at edge N+1 and `tx` falls after edge N+1.
- Frame length is 10×DIVISOR cycles. Back-to-back frames are exactly 10×DIVISOR apart.
- Simultaneous push and pop:
  - Level is unchanged.
  - When full, the push is accepted and no overflow is raised.
  - When empty, the pop does not occur: the pushed byte is not yet visible, and the pop happens on the next edge.
- `halt` rises after the accepting edge. `read_data` and `selected` have zero-cycle latency from `address`.

## Structure
- Shared package `console_pkg` holds:
  - register offsets: DATA=0, STATUS=1;
  - status bit indices;
  - the FSM state enum {IDLE, START, DATA, STOP};
  - the default HALT_CODE.
- Sub-module `byte_fifo` #(DEPTH): synchronous FIFO with push/pop/full/empty/level, reset as above.
- The top level holds address decode, status/halt registers and the transmit FSM.

## Test plan
- Reset, with DIVISOR=4: `tx`=1, `halt`=0, and status read at BASE_ADDR+1 returns 8'h02.
- Write 8'h48 to 16'h5a00: `tx` falls one cycle later. The bench decodes bits 0,0,0,1,0,0,1,0 at 4 cycles/bit, then a stop bit. `busy` drops after 40 cycles.
- Write "Hellorld" (8 bytes) back-to-back: frames are contiguous, with no idle cycles between stop and start. Decoded string matches. `fifo_level` peaks at 7.
- DEPTH=4, DIVISOR=16, write 6 bytes in consecutive cycles:
  - First byte is popped at once, the next 4 fill the FIFO, and the 6th is dropped.
  - Status reads 8'h0D (full, busy, overflow).
  - After a write to 16'h5a01, overflow is clear.
- Write 8'h11 then 8'h5a to 16'h5b00: `halt` stays 0 after the first write and rises after the second. A read of 16'h5b00 returns 8'h01.
- Assert `reset` low mid-DATA of a frame: `tx`=1 immediately and the FIFO is empty. After release, no further transmission occurs until a new write.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console peripheral: register offsets, status bits,
// transmit FSM states and the default halt code.
package console_pkg;

    localparam logic [15:0] REG_DATA   = 16'd0;
    localparam logic [15:0] REG_STATUS = 16'd1;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [7:0] DEFAULT_HALT_CODE = 8'h5a;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/console_port_if.sv
// CPU6 system-bus view of the console peripheral; the CPU side is the master.
interface console_port_if;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        selected;

    modport master (output address, write_en, write_data, input read_data, selected);
    modport slave  (input address, write_en, write_data, output read_data, selected);
endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with an explicit occupancy count so full/empty never alias.
// The caller only asserts push when there is room (or a pop coincides) and pop when non-empty.
module byte_fifo
    import console_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/console_port.sv
// Memory-mapped console: data register feeds a FIFO drained as 8N1 frames on tx,
// plus a status register and a sticky halt flag for ending simulations.
module console_port
    import console_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h5a00,
    parameter logic [15:0] HALT_ADDR = 16'h5b00,
    parameter logic [7:0]  HALT_CODE = DEFAULT_HALT_CODE,
    parameter int          DEPTH     = 16,
    parameter int          DIVISOR   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    console_port_if.slave          bus,
    output logic                   tx,
    output logic                   halt,
    output logic [$clog2(DEPTH):0] fifo_level
);
    // State | meaning
    // IDLE  | line idle (tx=1), waiting for a byte in the FIFO
    // START | start bit (tx=0) for DIVISOR cycles
    // DATA  | 8 data bits LSB first, DIVISOR cycles each
    // STOP  | stop bit (tx=1); chains straight into START if more data is queued
    localparam int              DIV_W    = $clog2(DIVISOR);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);

    tx_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             overflow;

    logic       sel_data, sel_status, sel_halt;
    logic       full, empty, push, pop, push_req, ovf_set, bit_end;
    logic [7:0] head;
    logic [7:0] status;

    assign sel_data   = (bus.address == BASE_ADDR + REG_DATA);
    assign sel_status = (bus.address == BASE_ADDR + REG_STATUS);
    assign sel_halt   = (bus.address == HALT_ADDR);
    assign bus.selected = sel_data | sel_status | sel_halt;

    assign bit_end  = (div_cnt == '0);
    assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_end));
    assign push_req = bus.write_en && sel_data;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_comb begin
        status             = 8'h00;
        status[STAT_FULL]  = full;
        status[STAT_EMPTY] = empty;
        status[STAT_BUSY]  = (state != IDLE);
        status[STAT_OVF]   = overflow;
    end

    always_comb begin
        bus.read_data = 8'h00;
        if (sel_status)    bus.read_data = status;
        else if (sel_halt) bus.read_data = {7'b0, halt};
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.write_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            halt     <= 1'b0;
        end else begin
            if (ovf_set)                          overflow <= 1'b1;
            else if (bus.write_en && sel_status)  overflow <= 1'b0;
            if (bus.write_en && sel_halt && bus.write_data == HALT_CODE) halt <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= head;
                        div_cnt <= DIV_LAST;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        div_cnt <= DIV_LAST;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        div_cnt <= DIV_LAST;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift   <= head;
                            div_cnt <= DIV_LAST;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
